// File: rtl/eq_gain_ramp.sv
// eq_gain_ramp: shadow/commit/ramp controller for the 8-band equalizer gains; `define EQ_SOFT_MUTE_EN adds a mute input
module eq_gain_ramp #(
   parameter int NBANDS = 8,
   parameter int GAIN_W = 8,
   parameter int STEP = 1,
   parameter int TICK_DIV = 4,
   parameter logic [GAIN_W-1:0] RESET_GAIN = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic wr_valid,
   output logic wr_ready,
   input  logic [2:0] wr_band,
   input  logic [GAIN_W-1:0] wr_gain,
   input  logic commit,
`ifdef EQ_SOFT_MUTE_EN
   input  logic mute,
`endif
   output logic [NBANDS-1:0][GAIN_W-1:0] g,
   output logic busy,
   output logic ramp_done
);
   localparam int DW = $clog2(TICK_DIV + 1);
   localparam logic signed [GAIN_W:0] STEP_P = STEP[GAIN_W:0];
   localparam logic signed [GAIN_W:0] STEP_N = -STEP_P;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   typedef enum logic [1:0] {IDLE, COMMIT, RAMP} state_t;
   state_t state;
   logic [NBANDS-1:0][GAIN_W-1:0] shadow, target, eff, nxt;
   logic signed [GAIN_W:0] d [NBANDS];
   logic [DW-1:0] div;
   logic update, mute_edge;
`ifdef EQ_SOFT_MUTE_EN
   logic mute_q;
   assign eff = mute ? '0 : target;
   assign mute_edge = mute ^ mute_q;
   // remember the last mute level so a change while idle restarts the ramp
   always_ff @(posedge clk or posedge rst)
      if (rst) mute_q <= 1'b0;
      else mute_q <= mute;
`else
   assign eff = target;
   assign mute_edge = 1'b0;
`endif
   // one bounded step toward the effective target; the 9-bit difference cannot overflow on a full swing
   for (genvar i = 0; i < NBANDS; i++) begin : g_band
      assign d[i] = $signed({eff[i][GAIN_W-1], eff[i]}) - $signed({g[i][GAIN_W-1], g[i]});
      assign nxt[i] = d[i] > STEP_P ? g[i] + STEP_P[GAIN_W-1:0] :
                      d[i] < STEP_N ? g[i] - STEP_P[GAIN_W-1:0] : eff[i];
   end
   assign update = state == RAMP && sample_tick && div == DIV_LAST;
   // accepted writes land in the shadow bank only; everything committed later reads from here
   always_ff @(posedge clk or posedge rst)
      if (rst) shadow <= {NBANDS{RESET_GAIN}};
      else if (wr_valid && wr_ready) shadow[wr_band] <= wr_gain;
   // control FSM with tick divider and live gains; all outputs registered with the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         target <= {NBANDS{RESET_GAIN}};
         g <= {NBANDS{RESET_GAIN}};
         div <= '0;
         busy <= 1'b0;
         ramp_done <= 1'b0;
         wr_ready <= 1'b1;
      end else begin
         ramp_done <= 1'b0;
         wr_ready <= 1'b1;
         if (update) g <= nxt;
         if (state == RAMP && sample_tick) div <= update ? '0 : div + 1'b1;
         case (state)
            IDLE:
               if (commit) begin
                  state <= COMMIT;
                  busy <= 1'b1;
                  wr_ready <= 1'b0;
               end else if (mute_edge) begin
                  state <= RAMP;
                  busy <= 1'b1;
               end
            COMMIT: begin
               target <= shadow;
               state <= RAMP;
            end
            RAMP:
               if (commit) begin
                  state <= COMMIT;
                  wr_ready <= 1'b0;
               end else if (g == eff) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  ramp_done <= 1'b1;
                  div <= '0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eq_gain_ramp.sv
// tb_eq_gain_ramp: scoreboard bench for eq_gain_ramp with STEP=1, TICK_DIV=4 and sample_tick on alternate cycles
module tb_eq_gain_ramp;
   localparam int STEP = 1;
   localparam int TICK_DIV = 4;
   typedef logic [7:0][7:0] gvec_t;
   typedef struct {bit done; int tk; gvec_t gv;} exp_t;
   logic clk = 0, rst = 0, sample_tick = 0, wr_valid = 0, commit = 0;
   logic [2:0] wr_band = '0;
   logic [7:0] wr_gain = '0;
`ifdef EQ_SOFT_MUTE_EN
   logic mute = 0;
`endif
   logic wr_ready, busy, ramp_done;
   gvec_t g, g_prev;
   exp_t q[$];
   int checks = 0, failures = 0, ramp_ticks = 0;
   bit in_ramp = 0;
   int mg[8], sh[8];

   eq_gain_ramp #(.STEP(STEP), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_band(wr_band), .wr_gain(wr_gain), .commit(commit),
`ifdef EQ_SOFT_MUTE_EN
      .mute(mute),
`endif
      .g(g), .busy(busy), .ramp_done(ramp_done));

   always #5 clk = ~clk;

   function automatic gvec_t pack(input int v[8]);
      gvec_t r;
      for (int i = 0; i < 8; i++) r[i] = 8'(v[i]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1 sample_tick = ~sample_tick;
   endtask

   // expected g after each ramp update, tagged with the ramp-tick count at which it must appear
   task automatic push_ramp(input int t[8]);
      int k, dd;
      bit moved;
      k = ramp_ticks / TICK_DIV + 1;
      moved = 1;
      while (moved) begin
         moved = 0;
         for (int i = 0; i < 8; i++) begin
            dd = t[i] - mg[i];
            dd = dd > STEP ? STEP : dd < -STEP ? -STEP : dd;
            if (dd != 0) moved = 1;
            mg[i] += dd;
         end
         if (moved) q.push_back('{1'b0, k * TICK_DIV, pack(mg)});
         k++;
      end
      q.push_back('{1'b1, 0, '0});
   endtask

   task automatic wr(input int band, input int gain);
      chk("wr_ready_before_write", wr_ready, 1);
      wr_valid = 1;
      wr_band = 3'(band);
      wr_gain = 8'(gain);
      step();
      wr_valid = 0;
      sh[band] = gain;
   endtask

   task automatic commit_pulse(input bit fresh, input int t[8]);
      commit = 1;
      step();
      commit = 0;
      in_ramp = 0;
      chk("busy_in_commit", busy, 1);
      chk("wr_ready_in_commit", wr_ready, 0);
      step();
      if (fresh) ramp_ticks = 0;
      in_ramp = 1;
      chk("wr_ready_after_commit", wr_ready, 1);
      push_ramp(t);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("scoreboard_drained", q.size(), 0);
      q.delete();
      in_ramp = 0;
      repeat (3) step();
      chk("busy_after_ramp", busy, 0);
   endtask

   task automatic mon_check(input bit is_done);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_output: g=%h ramp_done=%b with nothing expected", g, ramp_done);
         return;
      end
      e = q.pop_front();
      if (is_done && !e.done) begin
         failures++;
         $display("FAIL ramp_done_early: ramp_done=1, expected g=%h at tick %0d", e.gv, e.tk);
      end else if (!is_done && e.done) begin
         failures++;
         $display("FAIL g_after_settle: g=%h, expected ramp_done pulse", g);
      end else if (!is_done && (e.gv !== g || e.tk != ramp_ticks)) begin
         failures++;
         $display("FAIL g_update: g=%h at tick %0d, expected %h at tick %0d", g, ramp_ticks, e.gv, e.tk);
      end
   endtask

   // monitor: every change of g and every ramp_done pulse is matched against the scoreboard
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (g !== g_prev) mon_check(0);
         if (ramp_done) mon_check(1);
         if (sample_tick && in_ramp) ramp_ticks++;
      end
      g_prev = g;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t[8];
      mg = '{default: 0};
      sh = '{default: 0};
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_g", g, 0);
      chk("reset_busy", busy, 0);
      chk("reset_wr_ready", wr_ready, 1);
      chk("reset_ramp_done", ramp_done, 0);
      rst = 0;
      step();
      // band3 0 -> +10, one step every 4 ticks
      wr(3, 10);
      commit_pulse(1, sh);
      wait_idle(1000);
      // commit of unchanged targets: only a ramp_done pulse
      commit_pulse(1, sh);
      wait_idle(100);
      // back down to 0
      wr(3, 0);
      commit_pulse(1, sh);
      wait_idle(1000);
      // retarget mid-ramp: 0 -> 4, then toward -2 without breaking divider phase
      wr(3, 10);
      commit_pulse(1, sh);
      for (int n = 0; n < 400 && g[3] != 8'd4; n++) step();
      chk("g3_reached_4", g[3], 4);
      step();
      q.delete();
      mg = '{default: 0};
      mg[3] = 4;
      wr(3, -2);
      commit_pulse(0, sh);
      wait_idle(1000);
      // full-scale swings, including d = 255 on band0
      wr(7, 127);
      wr(0, -128);
      commit_pulse(1, sh);
      wait_idle(3000);
      wr(0, 127);
      commit_pulse(1, sh);
      wait_idle(5000);
      // write in the commit cycle is included; a write held into COMMIT stalls one cycle
      wr_valid = 1;
      wr_band = 3'd5;
      wr_gain = 8'd20;
      commit = 1;
      step();
      sh[5] = 20;
      commit = 0;
      wr_band = 3'd6;
      wr_gain = 8'd5;
      in_ramp = 0;
      chk("wr_ready_stall", wr_ready, 0);
      step();
      chk("wr_ready_released", wr_ready, 1);
      ramp_ticks = 0;
      in_ramp = 1;
      push_ramp(sh);
      step();
      wr_valid = 0;
      sh[6] = 5;
      wait_idle(2000);
      commit_pulse(1, sh);
      wait_idle(1000);
      // asynchronous reset in the middle of a ramp
      wr(2, 50);
      commit_pulse(1, sh);
      repeat (30) step();
      chk("busy_mid_ramp", busy, 1);
      q.delete();
      in_ramp = 0;
      rst = 1;
      #1;
      chk("async_reset_g", g, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_wr_ready", wr_ready, 1);
      step();
      step();
      rst = 0;
      mg = '{default: 0};
      sh = '{default: 0};
      step();
`ifdef EQ_SOFT_MUTE_EN
      wr(1, 12);
      commit_pulse(1, sh);
      wait_idle(1000);
      mute = 1;
      step();
      ramp_ticks = 0;
      in_ramp = 1;
      t = '{default: 0};
      push_ramp(t);
      wait_idle(1000);
      mute = 0;
      step();
      ramp_ticks = 0;
      in_ramp = 1;
      push_ramp(sh);
      wait_idle(1000);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
